// File: rtl/expr_eval_if.sv
// Character-stream and result bundle between a source and the expr_eval evaluator.
// The evaluator takes the slave side: it consumes characters and drives the result/done/err outputs.
interface expr_eval_if #(
  parameter int W = 16
);
  logic [7:0]   in;
  logic         in_valid;
  logic [W-1:0] result;
  logic         done;
  logic         err;

  modport master (
    output in,
    output in_valid,
    input  result,
    input  done,
    input  err
  );

  modport slave (
    input  in,
    input  in_valid,
    output result,
    output done,
    output err
  );
endinterface

// File: rtl/expr_eval.sv
// Evaluates single-digit +/* expressions terminated by '=', with * binding tighter than +.
// Latency: outputs are registered on the edge that accepts '='; always ready, no backpressure.
module expr_eval #(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        clr,
  expr_eval_if.slave  bus
);

  typedef enum logic [1:0] {
    S_NUM = 2'd0,
    S_OP  = 2'd1,
    S_ERR = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [W-1:0] sum, sum_nxt;
  logic [W-1:0] prod, prod_nxt;
  logic [W-1:0] result, result_nxt;
  logic         done, done_nxt;
  logic         err, err_nxt;

  logic         is_digit, is_plus, is_star, is_eq;
  logic [3:0]   digit;

  // Shift-and-add by a 4-bit digit keeps the datapath to a few adders.
  function automatic logic [W-1:0] mul_digit(input logic [W-1:0] a, input logic [3:0] d);
    logic [W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      if (d[i]) acc = acc + (a << i);
    end
    return acc;
  endfunction

  always_comb begin
    is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    is_plus  = (bus.in == 8'h2B);
    is_star  = (bus.in == 8'h2A);
    is_eq    = (bus.in == 8'h3D);
    digit    = bus.in[3:0];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= S_NUM;
      sum    <= '0;
      prod   <= ONE;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      sum    <= sum_nxt;
      prod   <= prod_nxt;
      result <= result_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sum_nxt    = sum;
    prod_nxt   = prod;
    result_nxt = result;
    done_nxt   = 1'b0;
    err_nxt    = err;

    if (bus.in_valid) begin
      // Any accepted character clears a sticky err left over from the previous '='.
      err_nxt = 1'b0;
      unique case (state)
        S_NUM: begin
          if (is_digit) begin
            prod_nxt  = mul_digit(prod, digit);
            state_nxt = S_OP;
          end else if (is_eq) begin
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
            sum_nxt   = '0;
            prod_nxt  = ONE;
            state_nxt = S_NUM;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_ERR;
          end
        end
        S_OP: begin
          if (is_star) begin
            state_nxt = S_NUM;
          end else if (is_plus) begin
            sum_nxt   = sum + prod;
            prod_nxt  = ONE;
            state_nxt = S_NUM;
          end else if (is_eq) begin
            result_nxt = sum + prod;
            done_nxt   = 1'b1;
            err_nxt    = 1'b0;
            sum_nxt    = '0;
            prod_nxt   = ONE;
            state_nxt  = S_NUM;
          end else begin
            // Covers a second digit in a row: multi-digit operands are malformed.
            err_nxt   = 1'b1;
            state_nxt = S_ERR;
          end
        end
        S_ERR: begin
          err_nxt = 1'b1;
          if (is_eq) begin
            done_nxt  = 1'b1;
            sum_nxt   = '0;
            prod_nxt  = ONE;
            state_nxt = S_NUM;
          end
        end
        default: begin
          state_nxt = S_NUM;
          sum_nxt   = '0;
          prod_nxt  = ONE;
        end
      endcase
    end
  end

  assign bus.result = result;
  assign bus.done   = done;
  assign bus.err    = err;

endmodule

// File: doc/expr_eval.md
# expr_eval

Arithmetic evaluator that sits directly downstream of the `expr` recogniser and consumes the same ASCII character stream. It accepts single-digit operands joined by `+` and `*`, applies normal precedence (`*` binds tighter than `+`), and closes each expression with `=`. On each `=` it reports the W-bit result and flags malformed input.

## Interface
- `W`, default 16: result and accumulator width.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `clr`  input  1  asynchronous, active-low reset.
- `in`  input  8  ASCII character.
- `in_valid`  input  1  `in` is accepted on a rising edge where `in_valid`=1. Otherwise `in` is ignored.
- `result`  output  W  value of the last well-formed expression.
- `done`  output  1  one-cycle pulse per accepted `=`.
- `err`  output  1  the current or just-terminated expression is malformed.

## Operation
- **Character classes:**
  - DIGIT: `0`–`9` (0x30–0x39), value d = in − 0x30.
  - PLUS: `+`
  - STAR: `*`
  - EQ: `=`
  - OTHER: everything else.
- **Internal registers:**
  - `sum` (W bits): completed terms.
  - `prod` (W bits): running product of the current term.
  - `state`
- **States:**
  - S_NUM: expecting an operand. This is the reset state.
  - S_OP: expecting an operator or `=`.
  - S_ERR: expression malformed; discard characters until `=`.
- **Transitions** (only on accepted characters):
  - S_NUM + DIGIT: `prod` ← `prod`·d (truncated to W bits), go to S_OP.
  - S_OP + STAR: go to S_NUM; `prod` is kept.
  - S_OP + PLUS: `sum` ← `sum` + `prod`, `prod` ← 1, go to S_NUM.
  - S_OP + EQ: `result` ← `sum` + `prod`, `done`=1, `err`=0. Then `sum` ← 0, `prod` ← 1, go to S_NUM.
  - S_NUM + EQ: this covers an empty expression or a trailing operator. `done`=1, `err`=1, `result` unchanged. Then `sum` ← 0, `prod` ← 1, go to S_NUM.
  - S_ERR + EQ: same response as S_NUM + EQ.
  - S_NUM + (PLUS, STAR or OTHER): go to S_ERR, `err` ← 1.
  - S_OP + (DIGIT or OTHER): go to S_ERR, `err` ← 1. This includes multi-digit operands.
  - S_ERR + anything other than EQ: stay in S_ERR.
- **Arithmetic:** all arithmetic is unsigned modulo 2^W, with no overflow flag. Multiplication is by a 4-bit constant 0–9 only; a full W×W multiplier is not required.
- **`err` behaviour:**
  - Rises the cycle after the offending character is accepted.
  - Stays high through the `done` cycle of the terminating `=`.
  - Clears on the first accepted character after that `done`.
  - Also cleared at a well-formed `=`, as listed above.

## Timing
- **Reset values:** `result`=0, `done`=0, `err`=0, `state`=S_NUM, `sum`=0, `prod`=1.
- **Asynchronous reset:** asserting `clr` low at any time, including mid-expression or during `done`, forces reset values immediately. The first accepted character after release starts a new expression.
- **Output registers:** all outputs are registered.
  - `result`, `done` and `err` change one clock after the edge that accepts `=`.
  - `done` is high for exactly one cycle.
  - `result` holds until the next well-formed `=`.
- **Throughput:** one character per cycle. Back-to-back expressions are allowed, so `=` followed immediately by a digit is valid.
- **Idle cycles:** cycles with `in_valid`=0 change no state. A `done` pulse already issued still lasts only its single cycle.
- **No backpressure:** the block is always ready.

## Test plan
- **Precedence:** with W=16, send "1+2*3=" back-to-back.
  - `done` pulses once, `result`=7, `err`=0.
- **Chained terms:** immediately follow with "2*3*4+5=".
  - `result`=29 and a second single `done` pulse.
- **Wrap-around:** send "9*9*9*9*9*9=".
  - `result`=7153 (531441 mod 65536), `err`=0.
- **Malformed input:** send "1++2=", then "12=".
  - Each `=` gives `done`=1 with `err`=1, and `result` stays at its prior value.
  - `err` drops on the next accepted character.
  - A following "4=" gives `result`=4, `err`=0.
- **Bubbles and empty expression:** send "3", then 3 cycles with `in_valid`=0 and `in`="+", then "=".
  - `result`=3 with no error.
  - A lone "=" then gives `done`=1, `err`=1.
- **Reset mid-expression:** send "5*", pulse `clr` low for 2 cycles, then send "2=".
  - All outputs read 0 during reset.
  - Afterwards `result`=2, not 10.
